// File: rtl/my_cpu_pkg.sv
// Shared definitions for the Hack-style CPU datapath: the address width,
// the C-instruction jump encodings and the jump-condition equation.
package my_cpu_pkg;

  localparam int WIDTH = 16;

  // Jump field {j1,j2,j3} = {lt, eq, gt}
  typedef enum logic [2:0] {
    J_NULL = 3'b000,
    JGT    = 3'b001,
    JEQ    = 3'b010,
    JGE    = 3'b011,
    JLT    = 3'b100,
    JNE    = 3'b101,
    JLE    = 3'b110,
    JMP    = 3'b111
  } jump_e;

  // Literal jump equation. zr and ng both high is illegal upstream, but the
  // result is still whatever this expression yields for that input.
  function automatic logic jump_take(
    input logic [2:0] j,
    input logic       is_c,
    input logic       zr,
    input logic       ng
  );
    logic lt_hit;
    logic eq_hit;
    logic gt_hit;
    lt_hit = j[2] & ng;
    eq_hit = j[1] & zr;
    gt_hit = j[0] & ~ng & ~zr;
    return is_c & (lt_hit | eq_hit | gt_hit);
  endfunction

endpackage

// File: rtl/my_jump_cond.sv
// Combinational jump-condition evaluator. Shared between the program counter
// and the CPU decoder so both see exactly the same jump decision.
module my_jump_cond
  import my_cpu_pkg::*;
(
  input  logic [2:0] j,
  input  logic       is_c,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  // Decision depends only on the current instruction and ALU flags
  always_comb begin
    take = jump_take(j, is_c, zr, ng);
  end

endmodule

// File: rtl/my_pc_16.sv
// Program counter for the Hack-style CPU. Each cycle it loads the jump target,
// increments, or holds under stall. It also flags a taken self-jump, which is
// how Hack programs park themselves at the end.
module my_pc_16 #(
  parameter int                 WIDTH      = my_cpu_pkg::WIDTH,
  parameter logic [WIDTH-1:0]   RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       j,
  input  logic             is_c,
  input  logic             zr,
  input  logic             ng,
  input  logic             stall,
  output logic [WIDTH-1:0] out,
  output logic             jumped,
  output logic             halted
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             take;
  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic             jumped_reg;
  logic             jumped_next;
  logic             halted_reg;
  logic             halted_next;

  my_jump_cond u_jump_cond (
    .j    (j),
    .is_c (is_c),
    .zr   (zr),
    .ng   (ng),
    .take (take)
  );

  // Next-state selection: stall holds everything, a taken jump loads the
  // target, otherwise count up and let the counter wrap silently.
  always_comb begin
    pc_next     = pc_reg;
    jumped_next = jumped_reg;
    halted_next = halted_reg;
    if (!stall) begin
      if (take) begin
        pc_next     = in;
        jumped_next = 1'b1;
        // A jump to our own address is the end-of-program loop; once seen
        // it stays latched until reset.
        if (in == pc_reg) begin
          halted_next = 1'b1;
        end
      end else begin
        pc_next     = pc_reg + ONE;
        jumped_next = 1'b0;
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg     <= RESET_ADDR;
      jumped_reg <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      pc_reg     <= pc_next;
      jumped_reg <= jumped_next;
      halted_reg <= halted_next;
    end
  end

  assign out    = pc_reg;
  assign jumped = jumped_reg;
  assign halted = halted_reg;

endmodule
